datapath: RTL and testbench

Single-bus 32-bit datapath for the RISC CPU, driven one control step at a time by an external control unit or testbench. It holds the register file R0–R15, PC, IR, MAR, MDR, HI/LO, the ALU operand latch Y and the 64-bit result register Z. All of these are joined by one shared 32-bit bus. It sits between the control unit, which drives the strobes, and the memory interface, which supplies Mdatain.

---
 rtl/datapath_pkg.sv | 64 ++++++
 rtl/datapath_alu.sv | 69 ++++++
 rtl/datapath.sv | 104 ++++++++++
 tb/tb_datapath.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath: ALU opcodes and bus-source priority.
package datapath_pkg;

   typedef enum logic [4:0] {
      OP_AND  = 5'b00011,
      OP_OR   = 5'b00100,
      OP_ADD  = 5'b00101,
      OP_SUB  = 5'b00110,
      OP_SHR  = 5'b00111,
      OP_SHRA = 5'b01000,
      OP_SHL  = 5'b01001,
      OP_ROR  = 5'b01010,
      OP_ROL  = 5'b01011,
      OP_MUL  = 5'b01100,
      OP_DIV  = 5'b01101,
      OP_NEG  = 5'b01110,
      OP_NOT  = 5'b01111
   } alu_op_e;

   // Declaration order is the bus priority order, highest first.
   typedef enum logic [3:0] {
      SRC_NONE,
      SRC_MDR,
      SRC_PC,
      SRC_ZHI,
      SRC_ZLO,
      SRC_HI,
      SRC_LO,
      SRC_C,
      SRC_REG
   } bus_src_e;

   function automatic bus_src_e bus_pick(
      input logic        mdr_out,
      input logic        pc_out,
      input logic        zhi_out,
      input logic        zlo_out,
      input logic        hi_out,
      input logic        lo_out,
      input logic        c_out,
      input logic [15:0] r_out
   );
      if (mdr_out)       return SRC_MDR;
      else if (pc_out)   return SRC_PC;
      else if (zhi_out)  return SRC_ZHI;
      else if (zlo_out)  return SRC_ZLO;
      else if (hi_out)   return SRC_HI;
      else if (lo_out)   return SRC_LO;
      else if (c_out)    return SRC_C;
      else if (|r_out)   return SRC_REG;
      else               return SRC_NONE;
   endfunction

   // Lowest-numbered asserted register drive wins.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int unsigned i = 16; i > 0; i--) begin
         if (v[i-1]) idx = 4'(i - 1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational 64-bit-result ALU: A = Y latch, B = bus.
// MUL/DIV exist only when DATAPATH_MULDIV_EN is defined.
module datapath_alu
   import datapath_pkg::*;
(
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [4:0]  opcode,
   output logic [63:0] result
);

   logic [4:0]  shamt;
   logic [31:0] ror_v;
   logic [31:0] rol_v;
   logic [31:0] sra_v;

   assign shamt = B[4:0];
   // Shifting a 32-bit value by 32 yields 0, so shamt == 0 degenerates cleanly.
   assign ror_v = (A >> shamt) | (A << (6'd32 - {1'b0, shamt}));
   assign rol_v = (A << shamt) | (A >> (6'd32 - {1'b0, shamt}));
   assign sra_v = $unsigned($signed(A) >>> shamt);

`ifdef DATAPATH_MULDIV_EN
   logic signed [63:0] prod;
   logic [31:0]        quo;
   logic [31:0]        rem;

   assign prod = $signed(A) * $signed(B);

   always_comb begin
      quo = '0;
      rem = '0;
      if (B == '0) begin
         quo = '1;
         rem = A;
      end else if (A == 32'h8000_0000 && B == '1) begin
         // Most-negative / -1 wraps to itself with zero remainder.
         quo = A;
         rem = '0;
      end else begin
         quo = $unsigned($signed(A) / $signed(B));
         rem = $unsigned($signed(A) % $signed(B));
      end
   end
`endif

   always_comb begin
      result = '0;
      case (alu_op_e'(opcode))
         OP_AND:  result = {32'h0, A & B};
         OP_OR:   result = {32'h0, A | B};
         OP_ADD:  result = {32'h0, A + B};
         OP_SUB:  result = {32'h0, A - B};
         OP_SHR:  result = {32'h0, A >> shamt};
         OP_SHRA: result = {32'h0, sra_v};
         OP_SHL:  result = {32'h0, A << shamt};
         OP_ROR:  result = {32'h0, ror_v};
         OP_ROL:  result = {32'h0, rol_v};
         OP_NEG:  result = {32'h0, 32'h0 - B};
         OP_NOT:  result = {32'h0, ~B};
`ifdef DATAPATH_MULDIV_EN
         OP_MUL:  result = prod;
         OP_DIV:  result = {rem, quo};
`endif
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC, IR, MAR, MDR, HI, LO, Y, Z on one shared bus.
// Optional MUL/DIV in the ALU is enabled by DATAPATH_MULDIV_EN.
module datapath
   import datapath_pkg::*;
(
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] Mdatain,
   input  logic        Read,
   input  logic        IncPC,
   input  logic [15:0] Rin,
   input  logic [15:0] Rout,
   input  logic        PCin,
   input  logic        IRin,
   input  logic        Zin,
   input  logic        MDRin,
   input  logic        MARin,
   input  logic        Yin,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        PCout,
   input  logic        Zhighout,
   input  logic        Zlowout,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        MDRout,
   input  logic        Cout,
   input  logic [4:0]  opcode,
   output logic [31:0] BusMuxOut
);

   logic [31:0] r_q [16];
   logic [31:0] pc_q, ir_q, mar_q, mdr_q, hi_q, lo_q, y_q;
   logic [63:0] z_q;

   logic [31:0] pc_d, mdr_d;
   logic [63:0] z_d;
   logic [31:0] bus;
   logic [31:0] c_sext;
   bus_src_e    src;
   logic [3:0]  reg_idx;

   assign src     = bus_pick(MDRout, PCout, Zhighout, Zlowout, HIout, LOout, Cout, Rout);
   assign reg_idx = lowest_set(Rout);
   assign c_sext  = {{13{ir_q[18]}}, ir_q[18:0]};

   always_comb begin
      bus = '0;
      case (src)
         SRC_MDR:  bus = mdr_q;
         SRC_PC:   bus = pc_q;
         SRC_ZHI:  bus = z_q[63:32];
         SRC_ZLO:  bus = z_q[31:0];
         SRC_HI:   bus = hi_q;
         SRC_LO:   bus = lo_q;
         SRC_C:    bus = c_sext;
         SRC_REG:  bus = r_q[reg_idx];
         default:  bus = '0;
      endcase
   end

   assign BusMuxOut = bus;

   datapath_alu u_alu (
      .A      (y_q),
      .B      (bus),
      .opcode (opcode),
      .result (z_d)
   );

   assign pc_d  = IncPC ? pc_q + 32'd1 : bus;
   assign mdr_d = Read ? Mdatain : bus;

   always_ff @(posedge Clock) begin
      if (clear) begin
         for (int unsigned i = 0; i < 16; i++) r_q[i] <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         y_q   <= '0;
         z_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < 16; i++) begin
            if (Rin[i]) r_q[i] <= bus;
         end
         if (PCin)  pc_q  <= pc_d;
         if (IRin)  ir_q  <= bus;
         if (MARin) mar_q <= bus;
         if (MDRin) mdr_q <= mdr_d;
         if (HIin)  hi_q  <= bus;
         if (LOin)  lo_q  <= bus;
         if (Yin)   y_q   <= bus;
         if (Zin)   z_q   <= z_d;
      end
   end

   // MAR and the IR opcode field are consumed by the memory interface and control unit outside this block.
   logic unused_state;
   assign unused_state = ^{mar_q, ir_q[31:19]};

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: spec-level model checks the bus every cycle, plus directed literal pins.
module tb_datapath;

   logic        Clock = 1'b0;
   logic        clear;
   logic [31:0] Mdatain;
   logic        Read, IncPC;
   logic [15:0] Rin, Rout;
   logic        PCin, IRin, Zin, MDRin, MARin, Yin, HIin, LOin;
   logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
   logic [4:0]  opcode;
   logic [31:0] BusMuxOut;

   int n_tests = 0;
   int n_fail  = 0;

   datapath dut (
      .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
      .Rin(Rin), .Rout(Rout), .PCin(PCin), .IRin(IRin), .Zin(Zin), .MDRin(MDRin),
      .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout),
      .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
      .MDRout(MDRout), .Cout(Cout), .opcode(opcode), .BusMuxOut(BusMuxOut)
   );

   always #5 Clock = ~Clock;

   // ---------------- behavioural model ----------------
   bit          m_valid = 1'b0;
   logic [31:0] m_r [16];
   logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y;
   logic [63:0] m_z;

   function automatic logic [31:0] model_bus();
      if (MDRout)   return m_mdr;
      if (PCout)    return m_pc;
      if (Zhighout) return m_z[63:32];
      if (Zlowout)  return m_z[31:0];
      if (HIout)    return m_hi;
      if (LOout)    return m_lo;
      if (Cout)     return {{13{m_ir[18]}}, m_ir[18:0]};
      for (int i = 0; i < 16; i++) if (Rout[i]) return m_r[i];
      return 32'h0;
   endfunction

   function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] w, t;
      int          s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = int'(b % 32);
      w  = {32'h0, a};
      case (op)
         5'd3:  return {32'h0, a & b};
         5'd4:  return {32'h0, a | b};
         5'd5:  begin t = 64'(a) + 64'(b); return {32'h0, t[31:0]}; end
         5'd6:  begin t = 64'(a) - 64'(b); return {32'h0, t[31:0]}; end
         5'd7:  begin t = w >> s; return {32'h0, t[31:0]}; end
         5'd8:  begin t = 64'(sa >>> s); return {32'h0, t[31:0]}; end
         5'd9:  begin t = w << s; return {32'h0, t[31:0]}; end
         5'd10: begin t = (w >> s) | (w << (32 - s)); return {32'h0, t[31:0]}; end
         5'd11: begin t = (w << s) | (w >> (32 - s)); return {32'h0, t[31:0]}; end
         5'd14: begin t = 64'(0) - 64'(b); return {32'h0, t[31:0]}; end
         5'd15: return {32'h0, ~b};
`ifdef DATAPATH_MULDIV_EN
         5'd12: return 64'(sa * sb);
         5'd13: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            t = {r[31:0], q[31:0]};
            return t;
         end
`endif
         default: return 64'h0;
      endcase
   endfunction

   always @(posedge Clock) begin
      logic [31:0] b;
      logic [63:0] res;
      b   = model_bus();
      res = model_alu(opcode, m_y, b);
      if (clear) begin
         for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
         m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_hi = 0; m_lo = 0; m_y = 0; m_z = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         for (int i = 0; i < 16; i++) if (Rin[i]) m_r[i] = b;
         if (PCin)  m_pc  = IncPC ? m_pc + 32'd1 : b;
         if (IRin)  m_ir  = b;
         if (MARin) m_mar = b;
         if (MDRin) m_mdr = Read ? Mdatain : b;
         if (HIin)  m_hi  = b;
         if (LOin)  m_lo  = b;
         if (Yin)   m_y   = b;
         if (Zin)   m_z   = res;
      end
   end

   always @(negedge Clock) begin
      logic [31:0] exp_bus;
      if (m_valid) begin
         exp_bus = model_bus();
         n_tests++;
         if (BusMuxOut !== exp_bus) begin
            n_fail++;
            $display("FAIL bus_cycle t=%0t got=%h exp=%h", $time, BusMuxOut, exp_bus);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic idle();
      clear = 0; Read = 0; IncPC = 0; Rin = '0; Rout = '0;
      PCin = 0; IRin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
      PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; Cout = 0;
      opcode = '0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #2;
      idle();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      Mdatain = v; Read = 1; MDRin = 1; tick();
   endtask

   initial begin
      Mdatain = '0;
      idle();
      clear = 1;
      tick();
      #1 check("reset_bus_idle", BusMuxOut, 32'h0);
      PCout = 1; #1 check("reset_pc", BusMuxOut, 32'h0); PCout = 0;
      Zlowout = 1; #1 check("reset_zlow", BusMuxOut, 32'h0); Zlowout = 0;

      // Register load and AND
      load_mdr(32'h12); MDRout = 1; Rin[2] = 1; tick();
      load_mdr(32'h14); MDRout = 1; Rin[3] = 1; tick();
      Rout[2] = 1; Yin = 1; tick();
      Rout[3] = 1; Zin = 1; opcode = 5'b00011; tick();
      Zlowout = 1; Rin[1] = 1; tick();
      Rout[1] = 1; #1 check("and_r1", BusMuxOut, 32'h10); Rout[1] = 0;

      // Bus priority
      MDRout = 1; Rout[2] = 1; #1 check("prio_mdr_over_r2", BusMuxOut, 32'h14); idle();
      Rout = 16'h000C; #1 check("prio_r2_over_r3", BusMuxOut, 32'h12); idle();
      #1 check("no_source_zero", BusMuxOut, 32'h0);

      // MUL
      Rout[2] = 1; Yin = 1; tick();
      Rout[3] = 1; Zin = 1; opcode = 5'b01100; tick();
`ifdef DATAPATH_MULDIV_EN
      Zlowout = 1; #1 check("mul_lo", BusMuxOut, 32'h168); idle();
`else
      Zlowout = 1; #1 check("mul_off_lo", BusMuxOut, 32'h0); idle();
`endif
      Zhighout = 1; #1 check("mul_hi", BusMuxOut, 32'h0); idle();
      load_mdr(32'hFFFF_FFFF); MDRout = 1; Rin[2] = 1; tick();
      Rout[2] = 1; Yin = 1; tick();
      Rout[3] = 1; Zin = 1; opcode = 5'b01100; tick();
`ifdef DATAPATH_MULDIV_EN
      Zhighout = 1; #1 check("mul_neg_hi", BusMuxOut, 32'hFFFF_FFFF); idle();
      Zlowout = 1; #1 check("mul_neg_lo", BusMuxOut, 32'hFFFF_FFEC); idle();
`else
      Zhighout = 1; #1 check("mul_off_neg_hi", BusMuxOut, 32'h0); idle();
`endif

      // DIV by zero and 20/6
      load_mdr(32'd7); MDRout = 1; Yin = 1; tick();
      Zin = 1; opcode = 5'b01101; tick();
`ifdef DATAPATH_MULDIV_EN
      Zlowout = 1; #1 check("div0_quo", BusMuxOut, 32'hFFFF_FFFF); idle();
      Zhighout = 1; #1 check("div0_rem", BusMuxOut, 32'h7); idle();
`else
      Zhighout = 1; #1 check("div_off_hi", BusMuxOut, 32'h0); idle();
`endif
      Rout[3] = 1; Yin = 1; tick();
      load_mdr(32'd6); MDRout = 1; Zin = 1; opcode = 5'b01101; tick();
`ifdef DATAPATH_MULDIV_EN
      Zlowout = 1; #1 check("div_quo", BusMuxOut, 32'd3); idle();
      Zhighout = 1; #1 check("div_rem", BusMuxOut, 32'd2); idle();
`else
      Zlowout = 1; #1 check("div_off_lo", BusMuxOut, 32'h0); idle();
`endif
      MDRout = 1; Zin = 1; opcode = 5'b00110; tick();
      Zlowout = 1; #1 check("sub_20_6", BusMuxOut, 32'd14); idle();

      // Sweep every opcode with A=0x80000011, B=5; model checks each Z half
      load_mdr(32'h8000_0011); MDRout = 1; Yin = 1; tick();
      load_mdr(32'd5);
      for (int op = 0; op < 32; op++) begin
         MDRout = 1; Zin = 1; opcode = 5'(op); tick();
         Zlowout = 1;
         #1;
         if (op == 10) check("ror_pin", BusMuxOut, 32'h8C00_0000);
         if (op == 8)  check("shra_pin", BusMuxOut, 32'hFC00_0000);
         tick();
         Zhighout = 1; tick();
      end

      // PC fetch from reset
      clear = 1; tick();
      PCout = 1; MARin = 1; tick();
      IncPC = 1; PCin = 1; tick();
      #1 check("fetch_mar", dut.mar_q, 32'h0);
      PCout = 1; #1 check("fetch_pc", BusMuxOut, 32'h1); idle();
      IncPC = 1; tick();
      PCout = 1; #1 check("incpc_alone", BusMuxOut, 32'h1); idle();
      load_mdr(32'h2891_8000); MDRout = 1; IRin = 1; tick();
      #1 check("fetch_ir", dut.ir_q, 32'h2891_8000);
      Cout = 1; #1 check("cout_sext", BusMuxOut, 32'h0001_8000); idle();

      // Read-before-write on Z
      PCout = 1; Yin = 1; tick();
      PCout = 1; Zin = 1; opcode = 5'b00101; tick();
      Zlowout = 1; Zin = 1; opcode = 5'b00101; tick();
      Zlowout = 1; #1 check("z_rbw", BusMuxOut, 32'h3); idle();

      // HI/LO, then clear overriding simultaneous loads
      load_mdr(32'hAA); MDRout = 1; HIin = 1; LOin = 1; tick();
      HIout = 1; #1 check("hi_load", BusMuxOut, 32'hAA); idle();
      clear = 1; Zin = 1; PCin = 1; MDRout = 1; opcode = 5'b00101; tick();
      MDRout = 1; #1 check("clr_mdr", BusMuxOut, 32'h0); idle();
      PCout = 1; #1 check("clr_pc", BusMuxOut, 32'h0); idle();
      Zlowout = 1; #1 check("clr_z", BusMuxOut, 32'h0); idle();
      LOout = 1; #1 check("clr_lo", BusMuxOut, 32'h0); idle();
      Rout[3] = 1; #1 check("clr_r3", BusMuxOut, 32'h0); idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
